// File: rtl/axi_atop_initiator.sv
// axi_atop_initiator
// Turns single RISC-V atomic requests (LR, SC, AMO*) into AXI5 ATOP or
// exclusive transactions on an AXI master port, one transaction at a time.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_*                 atomic request (op, byte addr, size, operand)
//   rsp_*                 result: old value / SC status, error flag
//   axi_mst_req_o/_rsp_i  AXI master port (struct types)
//
// Optional feature: define AXI_ATOP_INITIATOR_LRSC_EN to issue LR/SC as
// exclusive accesses. Without it LR/SC are rejected as illegal requests.

package axi_atop_initiator_pkg;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 4;

   typedef struct packed {
      logic [IW-1:0] id;  logic [AW-1:0] addr; logic [7:0] len;  logic [2:0] size;
      logic [1:0] burst;  logic lock;          logic [3:0] cache; logic [2:0] prot;
      logic [5:0] atop;
   } aw_chan_t;
   typedef struct packed {
      logic [IW-1:0] id;  logic [AW-1:0] addr; logic [7:0] len;  logic [2:0] size;
      logic [1:0] burst;  logic lock;          logic [3:0] cache; logic [2:0] prot;
   } ar_chan_t;
   typedef struct packed { logic [DW-1:0] data; logic [DW/8-1:0] strb; logic last; } w_chan_t;
   typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; } b_chan_t;
   typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_chan_t;

   typedef struct packed {
      aw_chan_t aw; logic aw_valid;
      w_chan_t  w;  logic w_valid;
      logic     b_ready;
      ar_chan_t ar; logic ar_valid;
      logic     r_ready;
   } req_t;
   typedef struct packed {
      logic aw_ready; logic ar_ready; logic w_ready;
      logic b_valid;  b_chan_t b;
      logic r_valid;  r_chan_t r;
   } rsp_t;

   localparam logic [3:0] OP_LR = 4'd0, OP_SC = 4'd1, OP_SWAP = 4'd2, OP_ADD = 4'd3,
                          OP_XOR = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_MIN = 4'd7,
                          OP_MAX = 4'd8, OP_MINU = 4'd9, OP_MAXU = 4'd10;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
endpackage

module axi_atop_initiator
   import axi_atop_initiator_pkg::*;
#(
   parameter int unsigned AxiAddrWidth   = axi_atop_initiator_pkg::AW,
   parameter int unsigned AxiDataWidth   = axi_atop_initiator_pkg::DW,
   parameter int unsigned AxiIdWidth     = axi_atop_initiator_pkg::IW,
   parameter logic [AxiIdWidth-1:0] AxiId = '0,
   parameter int unsigned RiscvWordWidth = 64,
   parameter int unsigned AxiAddrLSB     = $clog2(AxiDataWidth/8),
   parameter type axi_req_t = axi_atop_initiator_pkg::req_t,
   parameter type axi_rsp_t = axi_atop_initiator_pkg::rsp_t
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [3:0]                req_op_i,
   input  logic [AxiAddrWidth-1:0]   req_addr_i,
   input  logic                      req_size_i,
   input  logic [RiscvWordWidth-1:0] req_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [RiscvWordWidth-1:0] rsp_rdata_o,
   output logic                      rsp_err_o,
   output axi_req_t                  axi_mst_req_o,
   input  axi_rsp_t                  axi_mst_rsp_i
);
   localparam int unsigned StrbW = AxiDataWidth/8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
   state_e state_q, state_d;

   logic [3:0]                op_q, op_d;
   logic [AxiAddrWidth-1:0]   addr_q, addr_d;
   logic                      size_q, size_d;
   logic [RiscvWordWidth-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, ar_pend_q, ar_pend_d;
   logic b_pend_q, b_pend_d, r_pend_q, r_pend_d;

   logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
   logic req_hs, req_lrsc, req_illegal;
   logic [5:0] atop;
   logic [RiscvWordWidth-1:0] opnd;
   logic [63:0] opnd64;
   logic [AxiDataWidth-1:0] w_data, r_word;
   logic [StrbW-1:0] w_strb;
   logic [RiscvWordWidth-1:0] r_val;
   logic [AxiAddrLSB-1:0] off;

   // Ready is forced low while reset is held so the core cannot sneak in a request.
   assign req_ready_o = (state_q == IDLE) && !rst_i;
   assign req_hs      = req_valid_i && req_ready_o;
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

   assign aw_valid = (state_q == ISSUE) && aw_pend_q;
   assign w_valid  = (state_q == ISSUE) && w_pend_q;
   assign ar_valid = (state_q == ISSUE) && ar_pend_q;
   assign b_ready  = (state_q == WAIT)  && b_pend_q;
   assign r_ready  = (state_q == WAIT)  && r_pend_q;
   assign off      = addr_q[AxiAddrLSB-1:0];

   // Request legality: op range, size vs. XLEN, natural alignment.
   assign req_lrsc = (req_op_i == OP_LR) || (req_op_i == OP_SC);
   always_comb begin
      req_illegal = (req_op_i > OP_MAXU) || (req_size_i && RiscvWordWidth == 32) ||
                    (req_size_i ? (req_addr_i[2:0] != 3'd0) : (req_addr_i[1:0] != 2'd0));
`ifndef AXI_ATOP_INITIATOR_LRSC_EN
      req_illegal = req_illegal || req_lrsc;
`endif
   end

   // AtomicLoad little-endian encodings; AND becomes CLR with an inverted operand.
   always_comb begin
      case (op_q)
         OP_SWAP: atop = 6'b110000;
         OP_ADD:  atop = 6'b100000;
         OP_XOR:  atop = 6'b100010;
         OP_AND:  atop = 6'b100001;
         OP_OR:   atop = 6'b100011;
         OP_MAX:  atop = 6'b100100;
         OP_MIN:  atop = 6'b100101;
         OP_MAXU: atop = 6'b100110;
         OP_MINU: atop = 6'b100111;
         default: atop = 6'b000000;
      endcase
   end

   // Operand is replicated across the whole bus so the addressed lane always holds it.
   always_comb begin
      opnd   = (op_q == OP_AND) ? ~wdata_q : wdata_q;
      opnd64 = 64'(opnd);
      w_data = '0;
      for (int i = 0; i < int'(StrbW); i++)
         w_data[8*i +: 8] = size_q ? opnd64[8*(i%8) +: 8] : opnd64[8*(i%4) +: 8];
      w_strb = (size_q ? StrbW'(8'hFF) : StrbW'(4'hF)) << off;
      r_word = axi_mst_rsp_i.r.data >> {off, 3'b000};
      r_val  = size_q ? r_word[RiscvWordWidth-1:0]
                      : RiscvWordWidth'($signed(r_word[31:0]));
   end

   always_comb begin
      axi_mst_req_o          = '0;
      axi_mst_req_o.aw.id    = AxiId;
      axi_mst_req_o.aw.addr  = addr_q;
      axi_mst_req_o.aw.size  = size_q ? 3'd3 : 3'd2;
      axi_mst_req_o.aw.burst = 2'b01;
      axi_mst_req_o.aw.atop  = (op_q == OP_SC) ? 6'b0 : atop;
      axi_mst_req_o.aw_valid = aw_valid;
      axi_mst_req_o.w.data   = w_data;
      axi_mst_req_o.w.strb   = w_strb;
      axi_mst_req_o.w.last   = 1'b1;
      axi_mst_req_o.w_valid  = w_valid;
      axi_mst_req_o.b_ready  = b_ready;
      axi_mst_req_o.ar.id    = AxiId;
      axi_mst_req_o.ar.addr  = addr_q;
      axi_mst_req_o.ar.size  = size_q ? 3'd3 : 3'd2;
      axi_mst_req_o.ar.burst = 2'b01;
      axi_mst_req_o.ar_valid = ar_valid;
      axi_mst_req_o.r_ready  = r_ready;
`ifdef AXI_ATOP_INITIATOR_LRSC_EN
      // Only LR uses AR, and only SC uses AW without an atop.
      axi_mst_req_o.aw.lock  = (op_q == OP_SC);
      axi_mst_req_o.ar.lock  = 1'b1;
`endif
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      size_d    = size_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      aw_pend_d = aw_pend_q;
      w_pend_d  = w_pend_q;
      ar_pend_d = ar_pend_q;
      b_pend_d  = b_pend_q;
      r_pend_d  = r_pend_q;
      case (state_q)
         IDLE: if (req_hs) begin
            op_d    = req_op_i;
            addr_d  = req_addr_i;
            size_d  = req_size_i;
            wdata_d = req_wdata_i;
            rdata_d = '0;
            err_d   = req_illegal;
            if (req_illegal) state_d = RESP;
            else begin
               state_d   = ISSUE;
               ar_pend_d = (req_op_i == OP_LR);
               r_pend_d  = (req_op_i != OP_SC);
               aw_pend_d = (req_op_i != OP_LR);
               w_pend_d  = (req_op_i != OP_LR);
               b_pend_d  = (req_op_i != OP_LR);
            end
         end
         ISSUE: begin
            if (aw_valid && axi_mst_rsp_i.aw_ready) aw_pend_d = 1'b0;
            if (w_valid  && axi_mst_rsp_i.w_ready)  w_pend_d  = 1'b0;
            if (ar_valid && axi_mst_rsp_i.ar_ready) ar_pend_d = 1'b0;
            if (!aw_pend_d && !w_pend_d && !ar_pend_d) state_d = WAIT;
         end
         WAIT: begin
            if (b_ready && axi_mst_rsp_i.b_valid) begin
               b_pend_d = 1'b0;
               if (axi_mst_rsp_i.b.resp[1]) err_d = 1'b1;
`ifdef AXI_ATOP_INITIATOR_LRSC_EN
               // SC status: only EXOKAY means the reservation held.
               if (op_q == OP_SC)
                  rdata_d = (axi_mst_rsp_i.b.resp == RESP_EXOKAY) ? '0 : RiscvWordWidth'(1);
`endif
            end
            if (r_ready && axi_mst_rsp_i.r_valid) begin
               r_pend_d = 1'b0;
               rdata_d  = r_val;
               if (axi_mst_rsp_i.r.resp[1]) err_d = 1'b1;
            end
            if (!b_pend_d && !r_pend_d) state_d = RESP;
         end
         RESP: if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         op_q      <= '0;
         addr_q    <= '0;
         size_q    <= 1'b0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         ar_pend_q <= 1'b0;
         b_pend_q  <= 1'b0;
         r_pend_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
         ar_pend_q <= ar_pend_d;
         b_pend_q  <= b_pend_d;
         r_pend_q  <= r_pend_d;
      end
   end

   logic unused_rsp;
   assign unused_rsp = ^{axi_mst_rsp_i.b.id, axi_mst_rsp_i.r.id, axi_mst_rsp_i.r.last};

endmodule
